// File: rtl/reg_rotator_pkg.sv
// Shared encodings for the register-exchange engine: step types and FSM states.
package reg_rotator_pkg;

    // Step type applied to every channel on each RUN edge.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_ROTL = 2'b01,
        MODE_ROTR = 2'b10,
        MODE_SWAP = 2'b11
    } mode_t;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/reg_rotator_rot_step.sv
// Combinational next-value network: applies one rotate/swap/hold step to the
// whole channel vector. Every output channel is computed from the input vector
// only, so the caller gets a fully simultaneous update when it registers it.
module rot_step
    import reg_rotator_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS*WIDTH-1:0] ch_in,
    input  logic [1:0]                mode,
    output logic [CHANNELS*WIDTH-1:0] ch_out
);

    // Build the stepped vector; channels not touched by a mode keep their value.
    always_comb begin
        // NOTE: default assignment first so every path drives ch_out; no latch.
        ch_out = ch_in;
        case (mode_t'(mode))
            MODE_ROTL: begin
                for (int i = 0; i < CHANNELS; i++)
                    ch_out[((i + 1) % CHANNELS)*WIDTH +: WIDTH] = ch_in[i*WIDTH +: WIDTH];
            end
            MODE_ROTR: begin
                for (int i = 0; i < CHANNELS; i++)
                    ch_out[i*WIDTH +: WIDTH] = ch_in[((i + 1) % CHANNELS)*WIDTH +: WIDTH];
            end
            MODE_SWAP: begin
                // With odd CHANNELS the last channel has no partner and holds.
                for (int k = 0; k < CHANNELS / 2; k++) begin
                    ch_out[(2*k)*WIDTH     +: WIDTH] = ch_in[(2*k + 1)*WIDTH +: WIDTH];
                    ch_out[(2*k + 1)*WIDTH +: WIDTH] = ch_in[(2*k)*WIDTH     +: WIDTH];
                end
            end
            default: ; // MODE_HOLD: keep the default copy
        endcase
    end

endmodule

// File: rtl/reg_rotator.sv
// Register-exchange engine: CHANNELS registers of WIDTH bits that run a
// programmed number of simultaneous rotate/swap steps on command.
module reg_rotator
    import reg_rotator_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [1:0]                mode,
    input  logic                      start,
    input  logic [CNT_W-1:0]          steps,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CNT_W-1:0]          step_count
);

    state_t                    state;
    state_t                    state_nxt;
    logic [1:0]                mode_q;
    logic [CNT_W-1:0]          rem;
    logic [CHANNELS*WIDTH-1:0] stepped;

    rot_step #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_rot_step (
        .ch_in  (dout),
        .mode   (mode_q),
        .ch_out (stepped)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: load wins over start in IDLE; RUN ends on the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!load && start)
                    state_nxt = (steps != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                if (rem == CNT_W'(1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so no input reaches them combinationally.
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Channel registers, latched command and step counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the channels are plain flops, not a RAM, so they are cleared
            // by reset along with the control state.
            dout       <= '0;
            mode_q     <= MODE_HOLD;
            rem        <= '0;
            step_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        dout <= din;
                    end else if (start) begin
                        mode_q <= mode;
                        rem    <= steps;
                    end
                end
                ST_RUN: begin
                    dout       <= stepped;
                    rem        <= rem - CNT_W'(1);
                    step_count <= step_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_rotator.sv
// Self-checking bench for reg_rotator (WIDTH=8, CHANNELS=4): a transaction-level
// model tracks channels as an array and runs as a remaining-step count; outputs
// are compared every cycle, plus hand-computed literal checks.
module tb_reg_rotator;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 8;
    localparam logic [31:0] LOAD_VAL = 32'h2C21160B; // ch0..ch3 = 11,22,33,44

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      load = 1'b0;
    logic                      start = 1'b0;
    logic [1:0]                mode = 2'b00;
    logic [CNT_W-1:0]          steps = '0;
    logic [CHANNELS*WIDTH-1:0] din = '0;
    logic                      busy;
    logic                      done;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic [CNT_W-1:0]          step_count;

    always #5 clk = ~clk;

    reg_rotator #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .mode       (mode),
        .start      (start),
        .steps      (steps),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .step_count (step_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_ch  [CHANNELS] = '{default: 8'h00};
    logic [7:0] m_old [CHANNELS] = '{default: 8'h00};
    int         m_rem  = 0;      // steps still to apply; >0 means busy
    bit         m_done = 1'b0;   // completion pulse pending for this cycle
    logic [1:0] m_mode = 2'b00;
    logic [7:0] m_cnt  = 8'h00;

    function automatic logic [31:0] m_pack();
        logic [31:0] v;
        for (int i = 0; i < CHANNELS; i++) v[i*8 +: 8] = m_ch[i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ch   = '{default: 8'h00};
            m_rem  = 0;
            m_done = 1'b0;
            m_mode = 2'b00;
            m_cnt  = 8'h00;
        end else if (m_rem > 0) begin
            m_old = m_ch;
            for (int i = 0; i < CHANNELS; i++) begin
                case (m_mode)
                    2'b01: m_ch[(i + 1) % CHANNELS] = m_old[i];
                    2'b10: m_ch[i] = m_old[(i + 1) % CHANNELS];
                    2'b11: m_ch[i] = ((i ^ 1) < CHANNELS) ? m_old[i ^ 1] : m_old[i];
                    default: ;
                endcase
            end
            m_cnt = m_cnt + 8'd1;
            m_rem = m_rem - 1;
            if (m_rem == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (load) begin
            for (int i = 0; i < CHANNELS; i++) m_ch[i] = din[i*8 +: 8];
        end else if (start) begin
            if (steps == 0) m_done = 1'b1;
            else begin
                m_rem  = int'(steps);
                m_mode = mode;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("dout", dout, m_pack());
            check("busy", busy, m_rem > 0);
            check("done", done, m_done);
            check("step_count", step_count, m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit l, input bit s, input logic [1:0] md,
                         input logic [7:0] n, input logic [31:0] d);
        @(negedge clk);
        load = l; start = s; mode = md; steps = n; din = d;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 600; k++) begin
            if (m_rem == 0 && !m_done && !busy && !done) break;
            @(negedge clk);
        end
        if (k == 600) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b done=%0b still active after 600 cycles", busy, done);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int bc;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_dout", dout, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", step_count, 8'h00);

        // Asynchronous reset in the middle of a run
        drive(1'b1, 1'b0, 2'b00, 8'd0, LOAD_VAL);
        drive(1'b0, 1'b1, 2'b01, 8'd10, 32'h0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_dout", dout, 32'h0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_cnt", step_count, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Rotate-left by one, with latency of busy/done pinned
        drive(1'b1, 1'b0, 2'b00, 8'd0, LOAD_VAL);
        drive(1'b0, 1'b1, 2'b01, 8'd1, 32'h0);
        check("rotl_busy", busy, 1'b1);
        check("rotl_done_early", done, 1'b0);
        @(negedge clk);
        check("rotl_done", done, 1'b1);
        check("rotl_dout", dout, 32'h21160B2C);
        check("rotl_cnt", step_count, 8'd1);
        @(negedge clk);
        check("rotl_done_pulse", done, 1'b0);

        // Pair-swap once, then twice (restores)
        drive(1'b1, 1'b0, 2'b00, 8'd0, LOAD_VAL);
        drive(1'b0, 1'b1, 2'b11, 8'd1, 32'h0);
        wait_idle();
        check("swap1_dout", dout, 32'h212C0B16);
        drive(1'b0, 1'b1, 2'b11, 8'd2, 32'h0);
        wait_idle();
        check("swap2_dout", dout, 32'h212C0B16);
        check("swap_cnt", step_count, 8'd4);

        // Rotate-right by five: busy for exactly five cycles
        drive(1'b1, 1'b0, 2'b00, 8'd0, LOAD_VAL);
        drive(1'b0, 1'b1, 2'b10, 8'd5, 32'h0);
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("rotr_busy_cycles", bc, 5);
        check("rotr_dout", dout, 32'h0B2C2116);
        check("rotr_cnt", step_count, 8'd9);

        // Zero-step start: immediate done, no data change
        drive(1'b0, 1'b1, 2'b01, 8'd0, 32'h0);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_dout", dout, 32'h0B2C2116);
        wait_idle();

        // load and start together: load wins, no run
        drive(1'b1, 1'b1, 2'b01, 8'd3, 32'hA1B2C3D4);
        check("ld_st_dout", dout, 32'hA1B2C3D4);
        check("ld_st_busy", busy, 1'b0);
        @(negedge clk);
        check("ld_st_busy2", busy, 1'b0);
        check("ld_st_done", done, 1'b0);

        // load/start during RUN are ignored
        drive(1'b0, 1'b1, 2'b01, 8'd10, 32'h0);
        drive(1'b1, 1'b1, 2'b11, 8'd7, 32'h55555555);
        wait_idle();
        check("run_ignore_dout", dout, 32'hC3D4A1B2);
        check("run_ignore_cnt", step_count, 8'd19);

        // step_count wraps: 255 + 255 = 510 mod 256 = 254
        do_reset();
        drive(1'b0, 1'b1, 2'b01, 8'd255, 32'h0);
        wait_idle();
        drive(1'b0, 1'b1, 2'b10, 8'd255, 32'h0);
        wait_idle();
        check("wrap_cnt", step_count, 8'd254);

        // Randomized traffic checked by the model every cycle
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 3) == 0);
            mode  = 2'($urandom_range(0, 3));
            steps = 8'($urandom_range(0, 6));
            din   = $urandom;
        end
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
